// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 4-bit shifter, one bit position per clock.
// Captures operand, direction and amount on start, steps the working register
// once per clock, then presents the result on data_out with a one-cycle done.
// Optional feature macro: SHIFT_ROTATE_EN (when defined, rotate=1 selects
// circular steps; otherwise every step zero-fills and rotate is ignored).

// One bit of the working register: picks its next value from the neighbour on
// the side the data is moving from.
module shift_bit_cell (
  input  logic right_shift,
  input  logic from_lo,
  input  logic from_hi,
  output logic bit_next
);
  assign bit_next = right_shift ? from_hi : from_lo;
endmodule

module shift_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       right_shift,
  input  logic       rotate,
  input  logic [2:0] shift_amt,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       busy,
  output logic       done
);
  localparam int NUM_LANES = 4;
  localparam int CNT_W     = 3;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [NUM_LANES-1:0] work_q, work_step;
  logic [CNT_W-1:0]     count_q;
  logic                 right_q;
  logic                 accept, last_step;
  logic                 fill_lo, fill_hi;

  // Bits shifted in at the ends: the opposite end bit when rotating, else 0.
`ifdef SHIFT_ROTATE_EN
  logic rot_q;
  assign fill_lo = rot_q & work_q[NUM_LANES-1];
  assign fill_hi = rot_q & work_q[0];
`else
  logic unused_rotate;
  assign unused_rotate = rotate;
  assign fill_lo = 1'b0;
  assign fill_hi = 1'b0;
`endif

  // Per-bit next-value muxes forming the single-step shifter.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic from_lo, from_hi;
    if (i == 0) begin : g_lo_edge
      assign from_lo = fill_lo;
    end else begin : g_lo_mid
      assign from_lo = work_q[i-1];
    end
    if (i == NUM_LANES-1) begin : g_hi_edge
      assign from_hi = fill_hi;
    end else begin : g_hi_mid
      assign from_hi = work_q[i+1];
    end
    shift_bit_cell u_cell (
      .right_shift (right_q),
      .from_lo     (from_lo),
      .from_hi     (from_hi),
      .bit_next    (work_step[i])
    );
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and status decode; start is only honoured in IDLE.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (shift_amt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (count_q == CNT_W'(1)) begin
          last_step = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, stepping, and result publication on the final step.
  always_ff @(posedge clock) begin
    if (reset) begin
      work_q   <= '0;
      count_q  <= '0;
      right_q  <= 1'b0;
      data_out <= '0;
    end else if (accept) begin
      work_q  <= data_in;
      count_q <= shift_amt;
      right_q <= right_shift;
      // Zero-length request publishes the operand unchanged.
      if (shift_amt == '0) data_out <= data_in;
    end else if (state_q == S_SHIFT) begin
      work_q  <= work_step;
      count_q <= count_q - CNT_W'(1);
      if (last_step) data_out <= work_step;
    end
  end

`ifdef SHIFT_ROTATE_EN
  // Rotate mode is latched with the request like the other controls.
  always_ff @(posedge clock) begin
    if (reset)       rot_q <= 1'b0;
    else if (accept) rot_q <= rotate;
  end
`endif

endmodule
